seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Parametrised sequential shift-add multiplier: control FSM and datapath (accumulator, multiplier shift register, bit counter) in one block.
- Successor to the fixed-width idle/add/shift control unit. Adds a WIDTH parameter, an on-chip datapath, a signed/unsigned mode, a done strobe and a held product.
- Used as a multi-cycle arithmetic unit with a start/ready handshake.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32; product is 2*WIDTH bits
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not to be overridden

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  request; accepted only while ready=1
sign_mode  input  1  0 = unsigned, 1 = two's-complement operands; sampled with start
multiplicand  input  WIDTH  operand B; sampled with start
multiplier  input  WIDTH  operand Q; sampled with start
product  output  2*WIDTH  result; held from DONE until the next accepted start
ready  output  1  Moore; 1 in IDLE
busy  output  1  Moore; 1 in ADD or SHIFT
done  output  1  Moore; 1-cycle strobe in DONE
load_regs  output  1  Mealy; start & ready (operand load this edge)
add_regs  output  1  Mealy; ADD state & Q[0]

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; A, C, Q, B, counter P, neg flag and product all cleared to 0.
  - Outputs: ready=1, busy=0, done=0, product=0.
- State encoding is 2 bits: IDLE, ADD, SHIFT, DONE.
- IDLE:
  - start=1 → ADD at the next edge (edge E0).
  - Load at E0: B=|multiplicand|, Q=|multiplier|, A=0, C=0, P=WIDTH.
  - neg = sign_mode & (msb(multiplicand) ^ msb(multiplier)).
  - Magnitudes are taken only when sign_mode=1. Magnitude of the most-negative value is 2^(WIDTH-1), which fits unsigned in WIDTH bits.
  - start=0 → remain in IDLE.
- ADD:
  - If Q[0]=1: {C,A} = A + B (WIDTH+1-bit sum).
  - P = P-1.
  - Always → SHIFT.
- SHIFT:
  - {C,A,Q} shifted right by 1; C becomes 0.
  - If P==0 → DONE, else → ADD.
  - On the final shift, the product register loads {A,Q} after the shift, two's-complement negated over 2*WIDTH bits when neg=1.
- DONE: done=1 for exactly one cycle, then → IDLE unconditionally.
- Latency:
  - Start accepted at E0. Edges E1..E2*WIDTH alternate ADD and SHIFT.
  - done is high in the cycle after E2*WIDTH; ready returns after E2*WIDTH+1.
  - Total is 2*WIDTH+2 cycles per operation (18 for WIDTH=8).
- Handshake:
  - start is ignored outside IDLE; no queuing.
  - start held high continuously re-triggers on each return to IDLE.
  - Operands may change freely after E0.
- product:
  - Changes only at the final-shift edge and on reset.
  - Stays stable through DONE and IDLE, including while a new operation is busy. It updates at that operation's final shift.
- Zero operand: no shortcut; full latency, product=0. With sign_mode=1 and a zero operand, the result is 0, never negative zero.
- Reset mid-operation: immediate return to IDLE, product cleared, no done pulse.
- Arithmetic: unsigned result exact over 2*WIDTH bits. Signed result in range [-(2^(2W-2)-2^(W-1)), 2^(2W-2)], always representable.

Test Plan:
1. WIDTH=8, unsigned, 13 × 11 → done in the 18th cycle after start (cycle after E16), product=143 (0x008F), ready=1 one cycle later.
2. Unsigned 255 × 255 → product=0xFE01. add_regs high in all 8 ADD cycles; busy high for exactly 16 cycles.
3. sign_mode=1, -3 (0xFD) × 5 → product=0xFFF1 (-15). Also -128 (0x80) × -128 → 0x4000.
4. sign_mode=1, 0 × -7 → product=0x0000. Also unsigned 0 × 200 → 0. Full 18-cycle latency and add_regs never asserted.
5. Start pulse at cycle 5 of a busy operation with different operands → ignored. First result correct and product held. A start asserted after ready returns computes the second result.
6. Assert reset during SHIFT (P=3) → same cycle: state IDLE, ready=1, busy=0, product=0, no done. A following 7 × 9 → 63.

Source files
------------

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, with optional
// two's-complement operands handled by sign-magnitude conversion.
module seq_multiplier #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 sign_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic                 load_regs,
    output logic                 add_regs
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADD   = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [WIDTH-1:0]   ONE_W  = 1;
    localparam logic [2*WIDTH-1:0] ONE_2W = 1;
    localparam logic [CNT_W-1:0]   ONE_P  = 1;
    localparam logic [CNT_W-1:0]   P_INIT = CNT_W'(WIDTH);

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   p_q, p_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic [WIDTH-1:0]   mag_b, mag_q;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] shifted;

    // Most-negative operand negates to itself, which reads as 2^(WIDTH-1) unsigned
    assign mag_b = (sign_mode && multiplicand[WIDTH-1]) ?
                   (~multiplicand + ONE_W) : multiplicand;
    assign mag_q = (sign_mode && multiplier[WIDTH-1]) ?
                   (~multiplier + ONE_W) : multiplier;

    assign sum     = {1'b0, a_q} + {1'b0, b_q};
    assign shifted = {c_q, a_q, q_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        b_d     = b_q;
        c_d     = c_q;
        p_d     = p_q;
        neg_d   = neg_q;
        prod_d  = prod_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ADD;
                    a_d     = '0;
                    c_d     = 1'b0;
                    b_d     = mag_b;
                    q_d     = mag_q;
                    p_d     = P_INIT;
                    neg_d   = sign_mode &
                              (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                end
            end
            S_ADD: begin
                if (q_q[0]) begin
                    {c_d, a_d} = sum;
                end
                p_d     = p_q - ONE_P;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                {a_d, q_d} = shifted;
                c_d        = 1'b0;
                if (p_q == '0) begin
                    state_d = S_DONE;
                    prod_d  = neg_q ? (~shifted + ONE_2W) : shifted;
                end else begin
                    state_d = S_ADD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            p_q     <= '0;
            neg_q   <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            b_q     <= b_d;
            c_q     <= c_d;
            p_q     <= p_d;
            neg_q   <= neg_d;
            prod_q  <= prod_d;
        end
    end

    assign product   = prod_q;
    assign ready     = (state_q == S_IDLE);
    assign busy      = (state_q == S_ADD) || (state_q == S_SHIFT);
    assign done      = (state_q == S_DONE);
    assign load_regs = start & ready;
    assign add_regs  = (state_q == S_ADD) & q_q[0];

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: directed and random operations, results
// predicted with plain integer arithmetic and matched by a done monitor.
module tb_seq_multiplier;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic           sign_mode = 1'b0;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic [2*W-1:0] product;
    logic           ready, busy, done, load_regs, add_regs;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] exp_q[$];

    seq_multiplier #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .sign_mode(sign_mode),
        .multiplicand(multiplicand),
        .multiplier(multiplier),
        .product(product),
        .ready(ready),
        .busy(busy),
        .done(done),
        .load_regs(load_regs),
        .add_regs(add_regs)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic sm,
                                               input logic [W-1:0] b,
                                               input logic [W-1:0] q);
        longint r;
        if (sm) r = longint'($signed(b)) * longint'($signed(q));
        else    r = longint'(b) * longint'(q);
        return r[2*W-1:0];
    endfunction

    // One add cycle per set bit of the multiplier magnitude
    function automatic int ref_adds(input logic sm, input logic [W-1:0] q);
        int v;
        int c;
        v = sm ? int'($signed(q)) : int'(q);
        if (v < 0) v = -v;
        c = 0;
        for (int i = 0; i < 32; i++) if (v[i]) c++;
        return c;
    endfunction

    always @(negedge clk) begin : monitor
        logic [2*W-1:0] e;
        if (reset && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got product %0h, none expected",
                         product);
            end else begin
                e = exp_q.pop_front();
                check("product", product, e);
            end
        end
    end

    task automatic run_op(input logic sm, input logic [W-1:0] b,
                          input logic [W-1:0] q, input int poke_at,
                          input int reset_at);
        int n, busy_n, add_n;
        logic stable, got_done;
        logic [2*W-1:0] prev, e;
        @(negedge clk);
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            check("ready_wait", 0, 1);
            return;
        end
        sign_mode = sm;
        multiplicand = b;
        multiplier = q;
        start = 1'b1;
        #1;
        check("load_regs", load_regs, 1);
        prev = product;
        e = ref_mul(sm, b, q);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        sign_mode = 1'($urandom);
        multiplicand = W'($urandom);
        multiplier = W'($urandom);
        n = 0;
        busy_n = 0;
        add_n = 0;
        stable = 1'b1;
        got_done = 1'b0;
        while (n < 2*W + 5 && !got_done) begin
            @(negedge clk);
            n++;
            if (busy) busy_n++;
            if (add_regs) add_n++;
            if (!done && product !== prev) stable = 1'b0;
            if (n == reset_at) begin
                reset = 1'b0;
                #1;
                check("rst_ready", ready, 1);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_product", product, 0);
                void'(exp_q.pop_back());
                @(negedge clk);
                @(negedge clk);
                check("rst_no_done", done, 0);
                reset = 1'b1;
                return;
            end
            if (n == poke_at) begin
                start = 1'b1;
                sign_mode = 1'($urandom);
                multiplicand = W'($urandom);
                multiplier = W'($urandom);
            end else begin
                start = 1'b0;
            end
            if (done) got_done = 1'b1;
        end
        check("done_latency", n, 2*W + 1);
        check("busy_cycles", busy_n, 2*W);
        check("add_cycles", add_n, ref_adds(sm, q));
        check("product_held", stable, 1);
        @(negedge clk);
        check("ready_after", ready, 1);
        check("done_width", done, 0);
        check("product_idle", product, e);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_ready", ready, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_product", product, 0);
        check("reset_add", add_regs, 0);
        reset = 1'b1;

        run_op(1'b0, 8'd13, 8'd11, 0, 0);
        run_op(1'b0, 8'd255, 8'd255, 0, 0);
        run_op(1'b1, 8'hFD, 8'd5, 0, 0);
        run_op(1'b1, 8'h80, 8'h80, 0, 0);
        run_op(1'b1, 8'd0, 8'hF9, 0, 0);
        run_op(1'b0, 8'd0, 8'd200, 0, 0);
        run_op(1'b0, 8'd100, 8'd3, 5, 0);
        run_op(1'b1, 8'h81, 8'h7F, 0, 0);
        run_op(1'b0, 8'd50, 8'd60, 0, 10);
        run_op(1'b0, 8'd7, 8'd9, 0, 0);
        repeat (40) begin
            run_op(1'($urandom), W'($urandom), W'($urandom), 0, 0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
